// File: rtl/ch375_defs.sv
`default_nettype none
// ============================================================================
// Module      : ch375_defs (package)
// Description : Definitions shared by the CH375 transmit and receive serial
//               paths. These are the line FSM states, the default bit period
//               and the command-flag bit position.
// Revision    : 1.0  initial release
// ============================================================================
package ch375_defs;

  // Serial line framing states: idle-high line, start, data bits, stop
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // 100 MHz system clock divided down to 19200 baud
  localparam int c_CLKS_PER_BIT_DEFAULT = 5208;

  // Bit 8 of a 9-bit word marks a CH375 command byte
  localparam int c_CMD_FLAG_BIT = 8;

endpackage : ch375_defs
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count. Full and empty are
//               derived from the level register only. A push while full is
//               therefore dropped even if a pop happens in the same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int                 c_AW   = $clog2(DEPTH);
  localparam int                 c_LW   = $clog2(DEPTH) + 1;
  localparam logic [c_LW-1:0]    c_FULL = c_LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_LW-1:0]  r_level;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_level == c_FULL);
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; no reset needed because reads are gated by the level
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/ch375_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : ch375_uart_tx
// Description : FIFO-buffered serial transmitter driving the CH375 RXD pin.
//               The frame is 1 start bit, DATA_BITS data bits LSB first and
//               1 stop bit. Frames are sent back-to-back while words remain
//               queued.
// Revision    : 1.0  initial release
// ============================================================================
module ch375_uart_tx
  import ch375_defs::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 9,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          tx
);

  localparam int              c_IW       = $clog2(DATA_BITS);
  localparam logic [15:0]     c_CNT_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic [c_IW-1:0] c_LAST_BIT = c_IW'(DATA_BITS - 1);

  tx_state_t              r_state;
  tx_state_t              w_state_next;
  logic [15:0]            r_baud;
  logic [c_IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0]   r_shreg;
  logic                   r_tx;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_bit_end;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (level)
  );

  assign w_bit_end = (r_baud == c_CNT_MAX);
  assign wr_ready  = !w_full;
  assign busy      = (r_state != IDLE) || !w_empty;
  assign tx        = r_tx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and FIFO pop; a pop always coincides with a new start bit
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_end && (r_bit_idx == c_LAST_BIT)) w_state_next = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Baud counter, shift register and registered line driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_tx      <= 1'b1;
    end else if (w_pop) begin
      r_shreg   <= w_head;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
        end
        START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shreg[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == c_LAST_BIT) begin
              r_tx <= 1'b1;
            end else begin
              // Present the next bit now; it becomes shreg[0] after the shift
              r_shreg   <= r_shreg >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shreg[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            r_tx   <= 1'b1;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
        end
      endcase
    end
  end

endmodule : ch375_uart_tx
`default_nettype wire

// File: tb/tb_ch375_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ch375_uart_tx
// Description : Self-checking bench for ch375_uart_tx. A fast instance
//               (4 clocks/bit) covers framing, back-to-back, FIFO-full and
//               reset cases. A default-rate instance covers bit timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ch375_uart_tx;

  localparam int c_CPB      = 4;
  localparam int c_SLOW_CPB = 5208;
  localparam int c_FRAME    = 11 * c_CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [8:0] wr_data;
  logic       wr_ready;
  logic [4:0] level;
  logic       busy;
  logic       tx;
  logic       s_valid;
  logic [8:0] s_data;
  logic       s_ready;
  logic [4:0] s_level;
  logic       s_busy;
  logic       s_tx;

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic [8:0] sb[$];

  ch375_uart_tx #(.CLKS_PER_BIT(c_CPB), .DATA_BITS(9), .FIFO_DEPTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .level(level), .busy(busy), .tx(tx)
  );

  ch375_uart_tx #(.CLKS_PER_BIT(c_SLOW_CPB), .DATA_BITS(9), .FIFO_DEPTH(16)) u_slow (
    .clk(clk), .rst_n(rst_n), .wr_valid(s_valid), .wr_data(s_data),
    .wr_ready(s_ready), .level(s_level), .busy(s_busy), .tx(s_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present a word and hold it until accepted; record it in the scoreboard
  task automatic push_word(input logic [8:0] w);
    bit done;
    done = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = w;
    for (int i = 0; i < 400 && !done; i++) begin
      if (wr_ready === 1'b1) begin
        @(posedge clk);
        sb.push_back(w);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check_eq("push_timeout", 1, 0);
  endtask

  // Decode one frame from the fast line by mid-bit sampling
  task automatic recv_frame(output logic [8:0] d, output int t0);
    bit ok;
    ok = 1'b0;
    d  = '0;
    t0 = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_eq("rx_start_timeout", 1, 0);
      return;
    end
    t0 = cyc;
    repeat (c_CPB / 2) @(negedge clk);
    check_eq("rx_start_bit", tx, 0);
    for (int b = 0; b < 9; b++) begin
      repeat (c_CPB) @(negedge clk);
      d[b] = tx;
    end
    repeat (c_CPB) @(negedge clk);
    check_eq("rx_stop_bit", tx, 1);
    if (sb.size() == 0) check_eq("rx_unexpected_frame", 1, 0);
    else                check_eq("rx_data", d, sb.pop_front());
  endtask

  task automatic wait_not_busy(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    int         t;
    int         ts[3];
    int         c0;
    int         c1;
    bit         ok;
    logic [8:0] d;
    logic [10:0] frame;

    wr_valid = 1'b0; wr_data = '0; s_valid = 1'b0; s_data = '0; rst_n = 1'b0;

    // Reset and idle
    repeat (10) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_ready", wr_ready, 1);
    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || wr_ready !== 1'b1 || level !== 5'd0 || busy !== 1'b0 ||
          s_tx !== 1'b1 || s_busy !== 1'b0) bad++;
    end
    check_eq("idle_bad_cycles", bad, 0);

    // Single command frame, cycle-exact waveform
    push_word(9'h1A5);
    @(negedge clk);
    wr_valid = 1'b0;
    check_eq("single_accept_tx", tx, 1);
    check_eq("single_accept_level", level, 1);
    check_eq("single_accept_busy", busy, 1);
    frame = {1'b1, 9'h1A5, 1'b0};
    bad = 0;
    for (int i = 0; i < c_FRAME; i++) begin
      @(negedge clk);
      if (tx !== frame[i / c_CPB]) bad++;
      if (i == c_FRAME - 1) check_eq("single_busy_last", busy, 1);
    end
    check_eq("single_wave_bad_cycles", bad, 0);
    @(negedge clk);
    check_eq("single_busy_end", busy, 0);
    sb.delete();

    // Back-to-back frames
    fork
      begin
        push_word(9'h001);
        push_word(9'h0FF);
        push_word(9'h100);
        @(negedge clk);
        wr_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 3; f++) begin
          recv_frame(d, t);
          ts[f] = t;
        end
      end
    join
    check_eq("b2b_gap01", ts[1] - ts[0], c_FRAME);
    check_eq("b2b_gap12", ts[2] - ts[1], c_FRAME);
    wait_not_busy("b2b_idle_timeout");
    check_eq("b2b_sb_empty", sb.size(), 0);

    // FIFO full: one frame on the line, then 17 pushes
    fork
      begin
        push_word(9'h0AA);
        @(negedge clk);
        wr_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
          if (tx === 1'b0) begin
            ok = 1'b1;
            break;
          end
          @(negedge clk);
        end
        check_eq("full_first_started", ok, 1);
        c0 = 0;
        for (int i = 0; i < 17; i++) begin
          push_word(9'(i * 37 + 5));
          if (i == 15) begin
            #1;
            check_eq("full_level", level, 16);
            check_eq("full_ready_low", wr_ready, 0);
            c0 = cyc;
          end
        end
        check_eq("full_17th_held", (cyc - c0) > 2, 1);
        @(negedge clk);
        wr_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 18; f++) recv_frame(d, t);
      end
    join
    wait_not_busy("full_idle_timeout");
    check_eq("full_sb_empty", sb.size(), 0);

    // Reset during data bit 3
    push_word(9'h155);
    @(negedge clk);
    wr_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("mid_start_seen", ok, 1);
    repeat (c_CPB + 3 * c_CPB + c_CPB / 2) @(negedge clk);
    check_eq("mid_bit3_low", tx, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", tx, 1);
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_busy", busy, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check_eq("mid_no_resume", bad, 0);
    push_word(9'h0C3);
    @(negedge clk);
    wr_valid = 1'b0;
    recv_frame(d, t);
    wait_not_busy("mid_idle_timeout");

    // Default bit rate
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 9'h055;
    check_eq("slow_ready", s_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    c0 = 0;
    c1 = 0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (s_tx === 1'b0) begin
        ok = 1'b1;
        c0 = cyc;
        break;
      end
      @(negedge clk);
    end
    check_eq("slow_start_seen", ok, 1);
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
        @(negedge clk);
        if (s_tx === 1'b1) begin
          ok = 1'b1;
          c1 = cyc;
          break;
        end
      end
      check_eq("slow_bit0_seen", ok, 1);
      if (ok) begin
        check_eq("slow_bit_width_ns", (c1 - c0) * 10, 52080);
        d = '0;
        repeat (c_SLOW_CPB / 2) @(negedge clk);
        d[0] = s_tx;
        for (int b = 1; b < 9; b++) begin
          repeat (c_SLOW_CPB) @(negedge clk);
          d[b] = s_tx;
        end
        repeat (c_SLOW_CPB) @(negedge clk);
        check_eq("slow_stop_bit", s_tx, 1);
        check_eq("slow_data", d, 9'h055);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ch375_uart_tx
`default_nettype wire
